// File: rtl/io_port_bank_pkg.sv
// io_port_pkg: shared constants and helpers for the io_port_bank slice.
//   - clog2()           : ceiling log2 used to size FIFO pointers/counters
//   - PTR_W             : pointer width for the default FIFO depth
//   - st_*()            : bit offsets of the fields inside status_data
package io_port_pkg;

    localparam int DEF_FIFO_DEPTH = 32'sd4;

    // Ceiling log2; clog2(1) is 0.
    function automatic int clog2(input int value);
        int r;
        r = 32'sd0;
        while ((32'sd1 << r) < value) begin
            r = r + 32'sd1;
        end
        return r;
    endfunction

    localparam int PTR_W = clog2(DEF_FIFO_DEPTH);

    // Status word: in_full bits, then FIFO empty bits, then FIFO full bits,
    // with the sticky error flag in the MSB.
    function automatic int st_in_full_base();
        return 32'sd0;
    endfunction

    function automatic int st_empty_base(input int num_in);
        return num_in;
    endfunction

    function automatic int st_full_base(input int num_in, input int num_out);
        return num_in + num_out;
    endfunction

    function automatic int st_err_bit(input int data_w);
        return data_w - 32'sd1;
    endfunction

endpackage

// File: rtl/io_port_bank_if.sv
// io_port_bank_if: CPU-side bus of the I/O port bank.
//   bus_data    : value pushed to the selected output port
//   port_sel    : port index from the instruction
//   inport_out  : pop the selected input port
//   outport_in  : push bus_data to the selected output port
//   in_data     : selected input holding register (to the bus mux)
//   status_data : status word (to the bus mux)
//   io_stall    : requested access cannot complete this cycle
// master = CPU / control unit side, slave = io_port_bank side.
interface io_port_bank_if #(
    parameter int DATA_W = 32,
    parameter int SEL_W  = 3
) ();
    logic [DATA_W-1:0] bus_data;
    logic [SEL_W-1:0]  port_sel;
    logic              inport_out;
    logic              outport_in;
    logic [DATA_W-1:0] in_data;
    logic [DATA_W-1:0] status_data;
    logic              io_stall;

    modport master (
        output bus_data, port_sel, inport_out, outport_in,
        input  in_data, status_data, io_stall
    );

    modport slave (
        input  bus_data, port_sel, inport_out, outport_in,
        output in_data, status_data, io_stall
    );
endinterface

// File: rtl/io_port_bank_out_fifo.sv
// io_out_fifo: single-clock FIFO backing one output port.
//   clk, reset_n : clock, synchronous active-low reset
//   push, din    : write din when not full
//   pop, dout    : advance past head when not empty; dout is the head
//   empty, full  : derived from the occupancy count
//   count        : occupancy, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module io_out_fifo
    import io_port_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DATA_W-1:0]        din,
    output logic [DATA_W-1:0]        dout,
    output logic                     empty,
    output logic                     full,
    output logic [clog2(DEPTH):0]    count
);
    localparam int AW = clog2(DEPTH);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [AW-1:0]     wr_ptr_r;
    logic [AW-1:0]     rd_ptr_r;
    logic [AW:0]       count_r;
    logic              wr_en_s;
    logic              rd_en_s;

    assign wr_en_s = push & ~full;
    assign rd_en_s = pop & ~empty;
    assign empty   = (count_r == {(AW+1){1'b0}});
    assign full    = (count_r == (AW+1)'(DEPTH));
    assign dout    = mem_r[rd_ptr_r];
    assign count   = count_r;

    // Storage, pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
            for (int k = 0; k < DEPTH; k++) begin
                mem_r[k] <= {DATA_W{1'b0}};
            end
        end else begin
            if (wr_en_s) begin
                mem_r[wr_ptr_r] <= din;
                wr_ptr_r        <= wr_ptr_r + 1'b1;
            end
            if (rd_en_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            case ({wr_en_s, rd_en_s})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end
endmodule

// File: rtl/io_port_bank.sv
// io_port_bank: NUM_IN single-entry input ports and NUM_OUT FIFO-buffered
// output ports on the CPU bus, selected by port_sel.
//   clk, reset_n   : clock, synchronous active-low reset
//   cpu            : CPU bus (io_port_bank_if.slave)
//   ext_in_*       : per-channel input valid/ready handshake + data
//   ext_out_*      : per-channel output FIFO head valid/ready + data
//   ext_out_hold   : last value accepted by each output port (display drive)
// Optional build macro IO_PORT_BANK_IRQ_EN adds irq_mask input and a
// registered irq output raised while any unmasked input port is full.
module io_port_bank
    import io_port_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int NUM_IN     = 2,
    parameter int NUM_OUT    = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int SEL_W      = 3
) (
    input  logic                      clk,
    input  logic                      reset_n,
    io_port_bank_if.slave             cpu,
    input  logic [NUM_IN*DATA_W-1:0]  ext_in_data,
    input  logic [NUM_IN-1:0]         ext_in_valid,
    output logic [NUM_IN-1:0]         ext_in_ready,
    output logic [NUM_OUT*DATA_W-1:0] ext_out_data,
    output logic [NUM_OUT-1:0]        ext_out_valid,
    input  logic [NUM_OUT-1:0]        ext_out_ready,
    output logic [NUM_OUT*DATA_W-1:0] ext_out_hold
`ifdef IO_PORT_BANK_IRQ_EN
    ,
    input  logic [NUM_IN-1:0]         irq_mask,
    output logic                      irq
`endif
);
    localparam int CNT_W = clog2(FIFO_DEPTH) + 1;

    if (NUM_IN + 2 * NUM_OUT > DATA_W - 1) begin : g_status_check
        $error("io_port_bank: status word too narrow for NUM_IN/NUM_OUT");
    end

    // Input side
    logic [DATA_W-1:0] hold_in_r [NUM_IN];
    logic [NUM_IN-1:0] in_full_r;
    logic [NUM_IN-1:0] in_cap_s;
    logic [NUM_IN-1:0] in_pop_s;
    logic [NUM_IN-1:0] in_full_nxt_s;
    // Output side
    logic [NUM_OUT-1:0] push_s;
    logic [NUM_OUT-1:0] pop_s;
    logic [NUM_OUT-1:0] fifo_empty_s;
    logic [NUM_OUT-1:0] fifo_full_s;
    logic [DATA_W-1:0]  fifo_dout_s  [NUM_OUT];
    logic [CNT_W-1:0]   fifo_count_s [NUM_OUT];
    logic [CNT_W-1:0]   cnt_nxt_s    [NUM_OUT];
    logic [DATA_W-1:0]  hold_out_r   [NUM_OUT];
    // Selection / status
    logic              sel_in_ok_s;
    logic              sel_out_ok_s;
    logic              sel_in_full_s;
    logic              sel_out_full_s;
    logic [DATA_W-1:0] in_data_s;
    logic              err_r;
    logic              err_nxt_s;
    logic [DATA_W-1:0] status_nxt_s;
    logic [DATA_W-1:0] status_r;

    assign sel_in_ok_s  = ({1'b0, cpu.port_sel} < (SEL_W+1)'(NUM_IN));
    assign sel_out_ok_s = ({1'b0, cpu.port_sel} < (SEL_W+1)'(NUM_OUT));

    // Port-select muxes; an out-of-range index matches nothing and reads 0.
    always_comb begin
        sel_in_full_s  = 1'b0;
        sel_out_full_s = 1'b0;
        in_data_s      = {DATA_W{1'b0}};
        for (int i = 0; i < NUM_IN; i++) begin
            sel_in_full_s = (cpu.port_sel == SEL_W'(i)) ? in_full_r[i] : sel_in_full_s;
            in_data_s     = (cpu.port_sel == SEL_W'(i)) ? hold_in_r[i] : in_data_s;
        end
        for (int j = 0; j < NUM_OUT; j++) begin
            sel_out_full_s = (cpu.port_sel == SEL_W'(j)) ? fifo_full_s[j] : sel_out_full_s;
        end
    end

    assign cpu.in_data  = in_data_s;
    assign cpu.io_stall = (cpu.inport_out & sel_in_ok_s & ~sel_in_full_s)
                        | (cpu.outport_in & sel_out_ok_s & sel_out_full_s);

    for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_in
        // Capture needs ~full and pop needs full, so they never coincide.
        assign in_cap_s[gi]      = ext_in_valid[gi] & ~in_full_r[gi];
        assign in_pop_s[gi]      = cpu.inport_out & (cpu.port_sel == SEL_W'(gi)) & in_full_r[gi];
        assign in_full_nxt_s[gi] = in_cap_s[gi] | (in_full_r[gi] & ~in_pop_s[gi]);
        assign ext_in_ready[gi]  = ~in_full_r[gi];
    end

    // Input holding registers; a pop only clears the full flag.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            in_full_r <= {NUM_IN{1'b0}};
            for (int i = 0; i < NUM_IN; i++) begin
                hold_in_r[i] <= {DATA_W{1'b0}};
            end
        end else begin
            in_full_r <= in_full_nxt_s;
            for (int i = 0; i < NUM_IN; i++) begin
                if (in_cap_s[i]) begin
                    hold_in_r[i] <= ext_in_data[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    for (genvar gj = 0; gj < NUM_OUT; gj++) begin : g_out
        // Fullness is judged on current state: a same-cycle pop does not
        // make room for a push.
        assign push_s[gj] = cpu.outport_in & (cpu.port_sel == SEL_W'(gj)) & ~fifo_full_s[gj];
        assign pop_s[gj]  = ext_out_ready[gj] & ~fifo_empty_s[gj];

        io_out_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (FIFO_DEPTH)
        ) u_fifo (
            .clk     (clk),
            .reset_n (reset_n),
            .push    (push_s[gj]),
            .pop     (pop_s[gj]),
            .din     (cpu.bus_data),
            .dout    (fifo_dout_s[gj]),
            .empty   (fifo_empty_s[gj]),
            .full    (fifo_full_s[gj]),
            .count   (fifo_count_s[gj])
        );

        assign ext_out_data[gj*DATA_W +: DATA_W] = fifo_dout_s[gj];
        assign ext_out_hold[gj*DATA_W +: DATA_W] = hold_out_r[gj];
        assign ext_out_valid[gj]                 = ~fifo_empty_s[gj];
    end

    // Shadow of the last accepted push per output port.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int j = 0; j < NUM_OUT; j++) begin
                hold_out_r[j] <= {DATA_W{1'b0}};
            end
        end else begin
            for (int j = 0; j < NUM_OUT; j++) begin
                if (push_s[j]) begin
                    hold_out_r[j] <= cpu.bus_data;
                end
            end
        end
    end

    // Post-edge FIFO occupancy, used to build the registered status word.
    always_comb begin
        for (int j = 0; j < NUM_OUT; j++) begin
            cnt_nxt_s[j] = fifo_count_s[j];
            case ({push_s[j], pop_s[j]})
                2'b10:   cnt_nxt_s[j] = fifo_count_s[j] + 1'b1;
                2'b01:   cnt_nxt_s[j] = fifo_count_s[j] - 1'b1;
                default: cnt_nxt_s[j] = fifo_count_s[j];
            endcase
        end
    end

    assign err_nxt_s = err_r
                     | (cpu.inport_out & ~sel_in_ok_s)
                     | (cpu.outport_in & ~sel_out_ok_s);

    // Status word assembled from next-state values so the registered copy
    // tracks the state with no extra lag, yet reads 0 while reset is held.
    always_comb begin
        status_nxt_s = {DATA_W{1'b0}};
        for (int i = 0; i < NUM_IN; i++) begin
            status_nxt_s[st_in_full_base() + i] = in_full_nxt_s[i];
        end
        for (int j = 0; j < NUM_OUT; j++) begin
            status_nxt_s[st_empty_base(NUM_IN) + j]         = (cnt_nxt_s[j] == {CNT_W{1'b0}});
            status_nxt_s[st_full_base(NUM_IN, NUM_OUT) + j] = (cnt_nxt_s[j] == CNT_W'(FIFO_DEPTH));
        end
        status_nxt_s[st_err_bit(DATA_W)] = err_nxt_s;
    end

    // Sticky error flag and status register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            err_r    <= 1'b0;
            status_r <= {DATA_W{1'b0}};
        end else begin
            err_r    <= err_nxt_s;
            status_r <= status_nxt_s;
        end
    end

    assign cpu.status_data = status_r;

`ifdef IO_PORT_BANK_IRQ_EN
    logic irq_r;

    // Interrupt follows the masked in_full flags one cycle later.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            irq_r <= 1'b0;
        end else begin
            irq_r <= |(in_full_r & irq_mask);
        end
    end

    assign irq = irq_r;
`endif

endmodule
